video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Generates VGA raster timing for the display path: pixel/line counters, active-area flag, line and frame strobes, hsync, vsync and data-enable.
- Sits directly upstream of the pixel output stage inside the display path, in the clk_pixel domain driven by the clock manager's display clock.
- Coordinates are presented early so a downstream pixel fetch can run ahead. Sync and DE are delayed by SYNC_DELAY cycles to line up with the fetched pixel.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- SYNC_DELAY, 2, cycles by which hsync/vsync/de lag pos_x/pos_y (0 allowed)
- COORD_W, 12, width of coordinate outputs
- FRAME_CNT_W, 16, width of frame counter

Ports:
- clk_pixel  input  1  pixel clock; all logic on its rising edge
- rst_pixel  input  1  synchronous, active-high reset
- en  input  1  clock enable; when low, the whole block holds state
- pos_x  output  COORD_W  current horizontal count, 0..H_TOTAL-1
- pos_y  output  COORD_W  current vertical count, 0..V_TOTAL-1
- active  output  1  pos_x<H_ACTIVE and pos_y<V_ACTIVE, aligned with pos_x/pos_y
- line_start  output  1  pos_x==0, aligned with pos_x/pos_y
- frame_start  output  1  pos_x==0 and pos_y==0, aligned with pos_x/pos_y
- hsync  output  1  horizontal sync at VGA level, delayed SYNC_DELAY cycles
- vsync  output  1  vertical sync at VGA level, delayed SYNC_DELAY cycles
- de  output  1  active delayed SYNC_DELAY cycles
- frame_count  output  FRAME_CNT_W  completed frames since reset, wrapping

Behaviour:
- Derived values:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800 by default).
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525 by default).
  - Elaboration error if any timing parameter is <1, if H_TOTAL or V_TOTAL exceeds 2^COORD_W, or if SYNC_DELAY<0.
- Raster order: active pixels, then front porch, then sync, then back porch, on both axes.
- Sync decode:
  - hsync is asserted while pos_x is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
  - vsync is asserted while pos_y is in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], for whole lines, changing only where pos_x==0.
  - Both are then delayed by the pipeline.
- Counting (on each edge with rst_pixel=0 and en=1):
  - pos_x increments. When pos_x==H_TOTAL-1 it wraps to 0 and pos_y increments.
  - When pos_y==V_TOTAL-1 and pos_x wraps, pos_y wraps to 0 and frame_count increments, modulo 2^FRAME_CNT_W.
- Reset (any edge with rst_pixel=1, regardless of en):
  - pos_x=0, pos_y=0, frame_count=0.
  - active=0, line_start=0, frame_start=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0.
  - All SYNC_DELAY pipeline stages are cleared to those deasserted levels.
- First cycle after reset release with en=1:
  - Outputs show pos=(0,0) with active=1, line_start=1, frame_start=1.
  - The first counter advance happens on the following edge.
  - Delayed outputs show deasserted levels for SYNC_DELAY cycles, then the sync/de for (0,0).
- en low:
  - Counters, frame_count, aligned flags and the delay pipeline all hold their values.
  - No strobe is re-issued when en returns high; a held strobe simply remains visible for the hold duration.
- Reset mid-frame: on the next edge the block is fully reinitialised as above. No partial line is completed.
- SYNC_DELAY=0: hsync/vsync/de are combinationally aligned with pos_x/pos_y (same cycle), still with the reset values above.
- Strobe widths: line_start and frame_start are one enabled cycle wide.
- Exact alignment: de equals active from SYNC_DELAY enabled cycles earlier.

Decomposition:
- video_modes_pkg:
  - Add a video_timing_t struct (h/v active, front, sync, back, polarities).
  - Add a function returning H_TOTAL/V_TOTAL.
  - The VMODE_* constants carry a video_timing_t, so a parent can map a mode onto these parameters.
- One sub-module, sig_delay:
  - Parameterised width, depth and reset value.
  - Synchronous reset, clock enable, depth 0 = passthrough.
  - Used once for {hsync, vsync, de}.

Test Plan:
- Default params, release reset after 3 cycles with en=1 -> first cycle: pos=(0,0), frame_start=1. Next frame_start exactly 420000 cycles later; frame_count=1 at that point.
- Default params, watch one line -> hsync low for exactly 96 cycles, first low 656+2 cycles after line_start. de high for 640 cycles per visible line, 480 lines per frame.
- Default params, watch a frame -> vsync low for 1600 cycles, beginning 2 cycles after pos=(0,490).
- Small mode (H 4/1/2/1, V 3/1/1/1, SYNC_DELAY=0, FRAME_CNT_W=2) -> exhaustive check of pos, active and sync against a reference model over 5 frames; frame_count sequence 0,1,2,3,0,1.
- en low for 7 cycles at pos=(100,20) -> all outputs frozen; resuming gives (101,20), and no cycles are lost from the line length.
- Assert rst_pixel one cycle at pos=(300,200) -> next cycle outputs are at reset values; after release the sequence restarts at (0,0) with frame_count=0.

Source files
------------

// File: rtl/video_modes_pkg.sv
// Video mode descriptions shared by the display path.
// Contents:
//   video_timing_t  - one raster mode: porches, sync widths and polarities
//   video_totals_t  - full line length and full frame height of a mode
//   calc_totals     - derives the totals from a video_timing_t
//   VMODE_*         - ready-made modes a parent can map onto the
//                     video_timing_gen parameters
package video_modes_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_front;
    logic [15:0] h_sync;
    logic [15:0] h_back;
    logic [15:0] v_active;
    logic [15:0] v_front;
    logic [15:0] v_sync;
    logic [15:0] v_back;
    logic        h_pol;
    logic        v_pol;
  } video_timing_t;

  typedef struct packed {
    logic [31:0] h_total;
    logic [31:0] v_total;
  } video_totals_t;

  // Standard 640x480 at 60 Hz, negative syncs.
  localparam video_timing_t VMODE_640X480_60 = '{
    h_active: 16'd640, h_front: 16'd16, h_sync: 16'd96, h_back: 16'd48,
    v_active: 16'd480, v_front: 16'd10, v_sync: 16'd2,  v_back: 16'd33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  // Standard 800x600 at 60 Hz, positive syncs.
  localparam video_timing_t VMODE_800X600_60 = '{
    h_active: 16'd800, h_front: 16'd40, h_sync: 16'd128, h_back: 16'd88,
    v_active: 16'd600, v_front: 16'd1,  v_sync: 16'd4,   v_back: 16'd23,
    h_pol: 1'b1, v_pol: 1'b1
  };

  // Every region of a line (or frame) is counted once, so the total is the
  // plain sum of the four regions.
  function automatic video_totals_t calc_totals(input video_timing_t t);
    video_totals_t r;
    r.h_total = 32'(t.h_active) + 32'(t.h_front) + 32'(t.h_sync) + 32'(t.h_back);
    r.v_total = 32'(t.v_active) + 32'(t.v_front) + 32'(t.v_sync) + 32'(t.v_back);
    return r;
  endfunction

endpackage

// File: rtl/video_timing_gen_sig_delay.sv
// sig_delay: fixed-length shift register with clock enable.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset, loads RESET_VAL into every stage
//   en_i   - clock enable; when low all stages hold
//   d_i    - WIDTH-bit input
//   q_o    - d_i delayed by DEPTH enabled cycles (DEPTH=0 is a wire)
module sig_delay #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_passthrough
    // With no stages the control inputs have nothing to act on.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Stage 0 takes the input, every later stage takes its predecessor.
    // Reset forces the deasserted level into the whole chain so nothing
    // stale leaks out after a mid-frame restart.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: VGA raster timing generator for the clk_pixel domain.
// Ports:
//   clk_pixel    - pixel clock, rising edge
//   rst_pixel    - synchronous active-high reset
//   en           - clock enable, whole block holds when low
//   pos_x/pos_y  - raster coordinates, presented early for pixel fetch
//   active, line_start, frame_start - flags aligned with pos_x/pos_y
//   hsync, vsync, de - sync and data enable, SYNC_DELAY cycles behind pos
//   frame_count  - completed frames since reset, wrapping
module video_timing_gen
  import video_modes_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int SYNC_DELAY  = 2,
  parameter int COORD_W     = 12,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk_pixel,
  input  logic                   rst_pixel,
  input  logic                   en,
  output logic [COORD_W-1:0]     pos_x,
  output logic [COORD_W-1:0]     pos_y,
  output logic                   active,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam video_timing_t TIMING = '{
    h_active: 16'(H_ACTIVE), h_front: 16'(H_FRONT),
    h_sync:   16'(H_SYNC),   h_back:  16'(H_BACK),
    v_active: 16'(V_ACTIVE), v_front: 16'(V_FRONT),
    v_sync:   16'(V_SYNC),   v_back:  16'(V_BACK),
    h_pol: (HSYNC_POL != 0), v_pol: (VSYNC_POL != 0)
  };
  localparam video_totals_t TOTALS = calc_totals(TIMING);
  localparam int H_TOTAL = int'(TOTALS.h_total);
  localparam int V_TOTAL = int'(TOTALS.v_total);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      SYNC_DELAY < 0 ||
      (COORD_W < 31 && (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)))) begin : g_bad_params
    $error("video_timing_gen: illegal timing parameters");
  end

  localparam logic                HS_ON    = TIMING.h_pol;
  localparam logic                VS_ON    = TIMING.v_pol;
  localparam logic [COORD_W-1:0]  X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0]  Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0]  X_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0]  Y_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0]  HS_FIRST = COORD_W'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W-1:0]  HS_LAST  = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0]  VS_FIRST = COORD_W'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W-1:0]  VS_LAST  = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic                   started_q;
  logic [COORD_W-1:0]     posX_q, posX_d;
  logic [COORD_W-1:0]     posY_q, posY_d;
  logic [FRAME_CNT_W-1:0] frameCount_q, frameCount_d;
  logic                   active_q, lineStart_q, frameStart_q;
  logic                   hsAligned_q, vsAligned_q;
  logic                   active_d, lineStart_d, frameStart_d;
  logic                   hsAligned_d, vsAligned_d;
  logic [2:0]             syncDelayed;

  // Next raster position. The first enabled edge after reset only presents
  // (0,0) with its flags; counting starts on the edge after that, hence the
  // started_q gate.
  always_comb begin
    posX_d       = posX_q;
    posY_d       = posY_q;
    frameCount_d = frameCount_q;
    if (started_q) begin
      if (posX_q == X_LAST) begin
        posX_d = '0;
        if (posY_q == Y_LAST) begin
          posY_d       = '0;
          frameCount_d = frameCount_q + 1'b1;
        end else begin
          posY_d = posY_q + 1'b1;
        end
      end else begin
        posX_d = posX_q + 1'b1;
      end
    end
  end

  // Flags are decoded from the next position so they register together
  // with it. vsync depends on the row only, so it can only change when the
  // row changes, i.e. where pos_x returns to 0.
  always_comb begin
    active_d     = (posX_d < X_ACT) && (posY_d < Y_ACT);
    lineStart_d  = (posX_d == '0);
    frameStart_d = (posX_d == '0) && (posY_d == '0);
    hsAligned_d  = ((posX_d >= HS_FIRST) && (posX_d <= HS_LAST)) ? HS_ON : ~HS_ON;
    vsAligned_d  = ((posY_d >= VS_FIRST) && (posY_d <= VS_LAST)) ? VS_ON : ~VS_ON;
  end

  // Raster state. Reset wins over the enable; with en low every register,
  // including the strobes, holds its value.
  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      started_q    <= 1'b0;
      posX_q       <= '0;
      posY_q       <= '0;
      frameCount_q <= '0;
      active_q     <= 1'b0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
      hsAligned_q  <= ~HS_ON;
      vsAligned_q  <= ~VS_ON;
    end else if (en) begin
      started_q    <= 1'b1;
      posX_q       <= posX_d;
      posY_q       <= posY_d;
      frameCount_q <= frameCount_d;
      active_q     <= active_d;
      lineStart_q  <= lineStart_d;
      frameStart_q <= frameStart_d;
      hsAligned_q  <= hsAligned_d;
      vsAligned_q  <= vsAligned_d;
    end
  end

  // Sync and DE trail the coordinates so they line up with the pixel that
  // the downstream fetch returns for those coordinates.
  sig_delay #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL ({~HS_ON, ~VS_ON, 1'b0})
  ) u_sync_delay (
    .clk_i (clk_pixel),
    .rst_i (rst_pixel),
    .en_i  (en),
    .d_i   ({hsAligned_q, vsAligned_q, active_q}),
    .q_o   (syncDelayed)
  );

  assign pos_x       = posX_q;
  assign pos_y       = posY_q;
  assign frame_count = frameCount_q;
  assign active      = active_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;
  assign hsync       = syncDelayed[2];
  assign vsync       = syncDelayed[1];
  assign de          = syncDelayed[0];

endmodule
